noc_router_rr: RTL

//  Clocked, parametrised 5-port mesh router for the PE array NoC. Buffers each input in a FIFO,

---
 rtl/noc_router_rr_if.sv | 9 +
 rtl/noc_router_rr.sv | 109 ++++++++++
 2 files changed

// File: rtl/noc_router_rr_if.sv
// noc_router_rr_if: five-port valid/ready packet bundle for one mesh router tile
// Ports index p: 0 up, 1 down, 2 left, 3 right, 4 local; packet p lives at [p*W +: W].
// master = traffic side (drives in_*, out_ready), slave = router side.
interface noc_router_rr_if #(parameter int WIDTH_PKT = 32);
  logic [4:0] in_valid, in_ready, out_valid, out_ready;
  logic [5*WIDTH_PKT-1:0] in_data, out_data;
  modport master(output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
  modport slave(input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/noc_router_rr.sv
// noc_router_rr: 5-port XY mesh router with input FIFOs, round-robin arbiter and multicast copy
// Ports: clk, rst_n (async, active low), bus (slave modport: in_valid/in_data/in_ready in,
// out_valid/out_data/out_ready out). Packet: type [W-2:W-3], dst y [W-4:W-8], dst x [W-9:W-11].
module noc_router_rr #(
  parameter int WIDTH_PKT = 32,
  parameter int ADDRX = 0,
  parameter int ADDRY = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int DEPTH_R = 21,
  parameter int DEPTH_F = 5,
  parameter int MCAST_EN = 1
) (
  input logic clk,
  input logic rst_n,
  noc_router_rr_if.slave bus
);
  localparam int W = WIDTH_PKT;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [2:0] AX = 3'(ADDRX);
  localparam logic [4:0] AY = 5'(ADDRY);
  localparam bit F_OK = ADDRY != DEPTH_R - 1;
  localparam bit I_OK = ADDRY != 0 && ADDRX != DEPTH_F - 1;
  typedef enum logic [1:0] {IDLE, ORIG, COPY} state_t;
  state_t state;
  logic [4:0] empty, full, push, pop, ov;
  logic [4:0][W-1:0] head, od;
  logic [W-1:0] s1, cpy, pres;
  logic [4:0] py, sy;
  logic [2:0] px, sx, ptr, gnt, tgt;
  logic [3:0] k;
  logic up, gnt_v, move, cp_f, cp_i, cp_cond, s1_free;
  // up keeps in_ready low until the first edge after reset release
  assign bus.in_ready = {5{up}} & ~full;
  assign bus.out_valid = ov;
  assign bus.out_data = od;
  for (genvar p = 0; p < 5; p++) begin : g_fifo
    logic [W-1:0] mem [FIFO_DEPTH];
    logic [AW:0] wp, rp;
    assign empty[p] = wp == rp;
    assign full[p] = wp[AW-1:0] == rp[AW-1:0] && wp[AW] != rp[AW];
    assign push[p] = bus.in_valid[p] & bus.in_ready[p];
    assign pop[p] = gnt_v && gnt == 3'(p);
    assign head[p] = mem[rp[AW-1:0]];
    always_ff @(posedge clk)
      if (push[p]) mem[wp[AW-1:0]] <= bus.in_data[p*W +: W];
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        wp <= '0;
        rp <= '0;
      end else begin
        if (push[p]) wp <= wp + 1'b1;
        if (pop[p]) rp <= rp + 1'b1;
      end
  end
  always_comb begin
    sy = s1[W-4:W-8];
    sx = s1[W-9:W-11];
    cp_f = s1[W-2:W-3] == 2'b00 && F_OK;
    cp_i = s1[W-2:W-3] == 2'b01 && I_OK;
    cp_cond = MCAST_EN != 0 && {sy, sx} == {AY, AX} && (cp_f || cp_i);
    cpy = s1;
    cpy[W-4:W-11] = cp_f ? {sy + 5'd1, sx} : {sy - 5'd1, sx + 3'd1};
    pres = state == COPY ? cpy : s1;
    py = pres[W-4:W-8];
    px = pres[W-9:W-11];
    tgt = {py, px} == {AY, AX} ? 3'd4 : px > AX ? 3'd3 : px < AX ? 3'd2 : py > AY ? 3'd1 : 3'd0;
    move = state != IDLE && (!ov[tgt] || bus.out_ready[tgt]);
    // S1 can accept a new head unless it is moving an original that still owes a copy
    s1_free = state == IDLE || (move && !(state == ORIG && cp_cond));
  end
  // walk from the farthest candidate back to ptr so the closest non-empty FIFO wins
  always_comb begin
    gnt_v = 1'b0;
    gnt = 3'd0;
    k = 4'd0;
    for (int i = 4; i >= 0; i--) begin
      k = {1'b0, ptr} + 4'(i);
      k = k >= 4'd5 ? k - 4'd5 : k;
      if (!empty[k[2:0]]) begin
        gnt_v = s1_free;
        gnt = k[2:0];
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      s1 <= '0;
      ptr <= 3'd0;
      up <= 1'b0;
    end else begin
      up <= 1'b1;
      if (gnt_v) begin
        state <= ORIG;
        s1 <= head[gnt];
        ptr <= gnt == 3'd4 ? 3'd0 : gnt + 3'd1;
      end else if (move) state <= state == ORIG && cp_cond ? COPY : IDLE;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ov <= '0;
      od <= '0;
    end else
      for (int i = 0; i < 5; i++)
        if (move && tgt == 3'(i)) begin
          ov[i] <= 1'b1;
          od[i] <= pres;
        end else if (bus.out_ready[i]) ov[i] <= 1'b0;
endmodule
